// File: rtl/group_scheduler.sv
// -----------------------------------------------------------------------------
// group_scheduler
//
// Round-robin scheduler for the top level of the hierarchical pixel-group
// arbiter. One requesting group is granted at a time through a one-hot enable
// map. The grant is held until the group releases or a watchdog expires. Each
// released grant is reported downstream as an (x, y, timestamp) event over a
// valid/ready handshake.
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous active-low reset
//   grp_req_i      [GRP_ROWS][GRP_COLS] group request map
//   grp_release_i  release from the currently enabled group
//   enable_o       [GRP_ROWS][GRP_COLS] one-hot-or-zero enable map
//   grp_x_o        column of the granted/reported group
//   grp_y_o        row of the granted/reported group
//   ts_o           timestamp captured in the selection cycle
//   evt_valid_o    event valid
//   evt_ready_i    downstream ready
//   busy_o         high whenever the FSM is not idle
//   timeout_o      one-cycle pulse when the watchdog revokes a grant
// -----------------------------------------------------------------------------
module group_scheduler #(
    parameter int GRP_ROWS = 4,
    parameter int GRP_COLS = 4,
    parameter int ADDR_W   = 2,
    parameter int TS_W     = 16,
    parameter int TIMEOUT  = 15
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [GRP_ROWS-1:0][GRP_COLS-1:0]  grp_req_i,
    input  logic                               grp_release_i,
    output logic [GRP_ROWS-1:0][GRP_COLS-1:0]  enable_o,
    output logic [ADDR_W-1:0]                  grp_x_o,
    output logic [ADDR_W-1:0]                  grp_y_o,
    output logic [TS_W-1:0]                    ts_o,
    output logic                               evt_valid_o,
    input  logic                               evt_ready_i,
    output logic                               busy_o,
    output logic                               timeout_o
);

    localparam int N      = GRP_ROWS * GRP_COLS;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [IDX_W-1:0]    grant_idx_reg, grant_idx_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [TS_W-1:0]     ts_cnt_reg;
    logic [N-1:0]        enable_reg, enable_next;
    logic [ADDR_W-1:0]   x_reg, x_next;
    logic [ADDR_W-1:0]   y_reg, y_next;
    logic [TS_W-1:0]     ts_reg, ts_next;
    logic                valid_reg, valid_next;
    logic                busy_reg, busy_next;
    logic                timeout_reg, timeout_next;

    // Flat views of the 2-D maps: bit index = row*GRP_COLS + col.
    logic [N-1:0] req_flat;

    genvar gi, gj;
    generate
        for (gi = 0; gi < GRP_ROWS; gi++) begin : g_row
            for (gj = 0; gj < GRP_COLS; gj++) begin : g_col
                assign req_flat[gi*GRP_COLS + gj] = grp_req_i[gi][gj];
                assign enable_o[gi][gj]           = enable_reg[gi*GRP_COLS + gj];
            end
        end
    endgenerate

    // Round-robin pick: first set request scanning from ptr upwards, wrapping.
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!sel_found && req_flat[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    logic [ADDR_W-1:0] sel_col;
    logic [ADDR_W-1:0] sel_row;
    logic [IDX_W-1:0]  ptr_after_grant;

    assign sel_col         = ADDR_W'(int'(sel_idx) % GRP_COLS);
    assign sel_row         = ADDR_W'(int'(sel_idx) / GRP_COLS);
    assign ptr_after_grant = (grant_idx_reg == IDX_W'(N-1)) ? '0 : grant_idx_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        grant_idx_next = grant_idx_reg;
        hold_cnt_next  = hold_cnt_reg;
        enable_next    = enable_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        ts_next        = ts_reg;
        valid_next     = valid_reg;
        timeout_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                enable_next = '0;
                valid_next  = 1'b0;
                if (sel_found) begin
                    state_next           = GRANT;
                    enable_next[sel_idx] = 1'b1;
                    x_next               = sel_col;
                    y_next               = sel_row;
                    ts_next              = ts_cnt_reg;
                    hold_cnt_next        = '0;
                    grant_idx_next       = sel_idx;
                end
            end
            GRANT: begin
                // Release takes priority over a watchdog expiring in the same cycle.
                if (grp_release_i) begin
                    state_next  = REPORT;
                    enable_next = '0;
                    valid_next  = 1'b1;
                end else if (hold_cnt_reg == HOLD_W'(TIMEOUT-1)) begin
                    state_next   = IDLE;
                    enable_next  = '0;
                    timeout_next = 1'b1;
                    ptr_next     = ptr_after_grant;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            REPORT: begin
                if (valid_reg && evt_ready_i) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                    ptr_next   = ptr_after_grant;
                end
            end
            default: begin
                state_next  = IDLE;
                enable_next = '0;
                valid_next  = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_idx_reg <= '0;
            hold_cnt_reg  <= '0;
            ts_cnt_reg    <= '0;
            enable_reg    <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            ts_reg        <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            grant_idx_reg <= grant_idx_next;
            hold_cnt_reg  <= hold_cnt_next;
            ts_cnt_reg    <= ts_cnt_reg + 1'b1;
            enable_reg    <= enable_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            ts_reg        <= ts_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign grp_x_o     = x_reg;
    assign grp_y_o     = y_reg;
    assign ts_o        = ts_reg;
    assign evt_valid_o = valid_reg;
    assign busy_o      = busy_reg;
    assign timeout_o   = timeout_reg;

endmodule

// File: tb/tb_group_scheduler.sv
// -----------------------------------------------------------------------------
// tb_group_scheduler
//
// Self-checking bench for group_scheduler (4x4 map, TIMEOUT=15, TS_W=16).
// Each step drives one cycle of inputs, pushes the expected registered
// outputs into a scoreboard queue, and pops/compares them #1 after the edge.
// -----------------------------------------------------------------------------
module tb_group_scheduler;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [3:0][3:0]      grp_req_i;
    logic                 grp_release_i;
    logic [3:0][3:0]      enable_o;
    logic [1:0]           grp_x_o;
    logic [1:0]           grp_y_o;
    logic [15:0]          ts_o;
    logic                 evt_valid_o;
    logic                 evt_ready_i;
    logic                 busy_o;
    logic                 timeout_o;

    always #5 clk_i = ~clk_i;

    group_scheduler #(
        .GRP_ROWS (4),
        .GRP_COLS (4),
        .ADDR_W   (2),
        .TS_W     (16),
        .TIMEOUT  (15)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .grp_req_i     (grp_req_i),
        .grp_release_i (grp_release_i),
        .enable_o      (enable_o),
        .grp_x_o       (grp_x_o),
        .grp_y_o       (grp_y_o),
        .ts_o          (ts_o),
        .evt_valid_o   (evt_valid_o),
        .evt_ready_i   (evt_ready_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    typedef struct {
        string       name;
        logic [15:0] req;
        logic        rel;
        logic        rdy;
        logic        sel;   // this cycle is a selection: capture expected timestamp
        logic [15:0] en;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [15:0] ts;
        logic        valid;
        logic        busy;
        logic        to;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    vec_t        sb[$];
    logic [15:0] ts_expect = '0;
    logic [15:0] edge_cnt;

    // Cycles elapsed since reset release: the value the free-running counter should hold.
    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) edge_cnt <= '0;
        else          edge_cnt <= edge_cnt + 16'd1;
    end

    function automatic vec_t mk(input string n, input logic [15:0] req, input logic rel,
                                input logic rdy, input logic sel, input logic [15:0] en,
                                input logic [1:0] x, input logic [1:0] y, input logic valid,
                                input logic busy, input logic to);
        vec_t v;
        v.name = n; v.req = req; v.rel = rel; v.rdy = rdy; v.sel = sel;
        v.en = en; v.x = x; v.y = y; v.ts = '0; v.valid = valid; v.busy = busy; v.to = to;
        return v;
    endfunction

    task automatic check_out(input vec_t e);
        logic [15:0] en;
        en = enable_o;
        checks++;
        if (en !== e.en || grp_x_o !== e.x || grp_y_o !== e.y || ts_o !== e.ts ||
            evt_valid_o !== e.valid || busy_o !== e.busy || timeout_o !== e.to) begin
            errors++;
            $display("FAIL %s: got en=%h x=%0d y=%0d ts=%h valid=%b busy=%b to=%b, expected en=%h x=%0d y=%0d ts=%h valid=%b busy=%b to=%b",
                     e.name, en, grp_x_o, grp_y_o, ts_o, evt_valid_o, busy_o, timeout_o,
                     e.en, e.x, e.y, e.ts, e.valid, e.busy, e.to);
        end else begin
            $display("ok   %s: en=%h x=%0d y=%0d ts=%h valid=%b busy=%b to=%b",
                     e.name, en, grp_x_o, grp_y_o, ts_o, evt_valid_o, busy_o, timeout_o);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        grp_req_i     = v.req;
        grp_release_i = v.rel;
        evt_ready_i   = v.rdy;
        if (v.sel) ts_expect = edge_cnt;
        e    = v;
        e.ts = ts_expect;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        check_out(e);
    endtask

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end else begin
            $display("ok   %s: %h", n, act);
        end
    endtask

    vec_t tbl[20];
    vec_t rst_v;

    initial begin
        // Reset, basic grant order, wrap, backpressure. Start with ptr = 0.
        tbl[0]  = mk("t1_grant2",      16'h0204, 0, 0, 1, 16'h0004, 2'd2, 2'd0, 0, 1, 0);
        tbl[1]  = mk("t1_release2",    16'h0204, 1, 0, 0, 16'h0000, 2'd2, 2'd0, 1, 1, 0);
        tbl[2]  = mk("t1_handshake2",  16'h0204, 0, 1, 0, 16'h0000, 2'd2, 2'd0, 0, 0, 0);
        tbl[3]  = mk("t1_grant9",      16'h0204, 0, 0, 1, 16'h0200, 2'd1, 2'd2, 0, 1, 0);
        tbl[4]  = mk("t1_release9",    16'h0000, 1, 0, 0, 16'h0000, 2'd1, 2'd2, 1, 1, 0);
        tbl[5]  = mk("t1_handshake9",  16'h0000, 0, 1, 0, 16'h0000, 2'd1, 2'd2, 0, 0, 0);
        tbl[6]  = mk("t2_grant15",     16'h8000, 0, 0, 1, 16'h8000, 2'd3, 2'd3, 0, 1, 0);
        tbl[7]  = mk("t2_release15",   16'h0000, 1, 0, 0, 16'h0000, 2'd3, 2'd3, 1, 1, 0);
        tbl[8]  = mk("t2_handshake15", 16'h0000, 0, 1, 0, 16'h0000, 2'd3, 2'd3, 0, 0, 0);
        tbl[9]  = mk("t2_grant0_wrap", 16'h8001, 0, 0, 1, 16'h0001, 2'd0, 2'd0, 0, 1, 0);
        tbl[10] = mk("t2_release0",    16'h8001, 1, 1, 0, 16'h0000, 2'd0, 2'd0, 1, 1, 0);
        tbl[11] = mk("t2_handshake0",  16'h0000, 0, 1, 0, 16'h0000, 2'd0, 2'd0, 0, 0, 0);
        tbl[12] = mk("t4_grant2",      16'h0004, 0, 0, 1, 16'h0004, 2'd2, 2'd0, 0, 1, 0);
        tbl[13] = mk("t4_release2",    16'h0004, 1, 0, 0, 16'h0000, 2'd2, 2'd0, 1, 1, 0);
        for (int i = 14; i < 19; i++)
            tbl[i] = mk("t4_stall",    16'hFFFF, 0, 0, 0, 16'h0000, 2'd2, 2'd0, 1, 1, 0);
        tbl[19] = mk("t4_ready",       16'h0000, 0, 1, 0, 16'h0000, 2'd2, 2'd0, 0, 0, 0);

        reset_i       = 1'b0;
        grp_req_i     = '0;
        grp_release_i = 1'b0;
        evt_ready_i   = 1'b0;
        #1;
        rst_v = mk("reset_state", 16'h0, 0, 0, 0, 16'h0, 2'd0, 2'd0, 0, 0, 0);
        check_out(rst_v);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;

        for (int i = 0; i < 20; i++) step(tbl[i]);

        // Watchdog: idx 5 held 15 cycles, then revoked with a one-cycle pulse.
        step(mk("t3_grant5", 16'h0020, 0, 0, 1, 16'h0020, 2'd1, 2'd1, 0, 1, 0));
        for (int i = 0; i < 14; i++)
            step(mk("t3_hold5", 16'h0000, 0, 0, 0, 16'h0020, 2'd1, 2'd1, 0, 1, 0));
        step(mk("t3_timeout", 16'h0000, 0, 0, 0, 16'h0000, 2'd1, 2'd1, 0, 0, 1));
        // Scan resumes at idx 6 even though 4 and 5 are requesting.
        step(mk("t3_next6", 16'h0070, 0, 0, 1, 16'h0040, 2'd2, 2'd1, 0, 1, 0));
        for (int i = 0; i < 14; i++)
            step(mk("t3_hold6", 16'h0000, 0, 0, 0, 16'h0040, 2'd2, 2'd1, 0, 1, 0));
        // Release on the last allowed cycle beats the watchdog.
        step(mk("t3_rel_at_limit", 16'h0000, 1, 0, 0, 16'h0000, 2'd2, 2'd1, 1, 1, 0));
        step(mk("t3_handshake6", 16'h0000, 0, 1, 0, 16'h0000, 2'd2, 2'd1, 0, 0, 0));

        // Timestamp wrap: select while the counter reads 0xFFFF.
        grp_req_i     = '0;
        grp_release_i = 1'b0;
        evt_ready_i   = 1'b0;
        for (int i = 0; i < 70000 && edge_cnt != 16'hFFFF; i++) begin
            @(posedge clk_i);
            #1;
        end
        cmp("t5_counter_reached", {16'h0, edge_cnt}, 32'h0000_FFFF);
        step(mk("t5_grant10_ffff", 16'h0400, 0, 0, 1, 16'h0400, 2'd2, 2'd2, 0, 1, 0));
        cmp("t5_ts_ffff", {16'h0, ts_o}, 32'h0000_FFFF);
        step(mk("t5_release10", 16'h0000, 1, 0, 0, 16'h0000, 2'd2, 2'd2, 1, 1, 0));
        step(mk("t5_handshake10", 16'h0000, 0, 1, 0, 16'h0000, 2'd2, 2'd2, 0, 0, 0));
        step(mk("t5_grant10_wrapped", 16'h0400, 0, 0, 1, 16'h0400, 2'd2, 2'd2, 0, 1, 0));
        cmp("t5_ts_0002", {16'h0, ts_o}, 32'h0000_0002);

        // Asynchronous reset in the middle of a grant (ptr is 11 here).
        #3;
        reset_i = 1'b0;
        #1;
        cmp("t6_enable_async_drop", {16'h0, enable_o}, 32'h0);
        cmp("t6_busy_async_drop", {31'h0, busy_o}, 32'h0);
        cmp("t6_valid_after_reset", {31'h0, evt_valid_o}, 32'h0);
        cmp("t6_timeout_after_reset", {31'h0, timeout_o}, 32'h0);
        cmp("t6_ts_after_reset", {16'h0, ts_o}, 32'h0);
        ts_expect = '0;
        grp_req_i = '0;
        @(negedge clk_i);
        reset_i = 1'b1;
        step(mk("t6_grant0_after_reset", 16'h8001, 0, 0, 1, 16'h0001, 2'd0, 2'd0, 0, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/group_scheduler.md
Name: group_scheduler

Overview:
- Top-level scheduler for the hierarchical pixel-group arbiter.
- Takes the per-group request map produced by a pixel_groups level and grants exactly one group at a time through a one-hot enable map, using round-robin order.
- Holds the enable until the granted group signals release, or until a watchdog timeout expires.
- Reports each completed group service as a timestamped (x, y) event over a valid/ready handshake to the downstream event encoder.

Parameters:
- GRP_ROWS, 4, rows in the group request/enable map.
- GRP_COLS, 4, columns in the group request/enable map.
- ADDR_W, 2, width of group x/y address; must satisfy 2**ADDR_W >= max(GRP_ROWS, GRP_COLS).
- TS_W, 16, width of the free-running timestamp.
- TIMEOUT, 15, maximum number of cycles enable is held without release; must be >= 1.

Ports:
- clk_i, in, 1, system clock. The block uses this single clock.
- reset_i, in, 1, asynchronous, active-low reset.
- grp_req_i, in, [GRP_ROWS-1:0][GRP_COLS-1:0], group request map (req_o of the pixel_groups level).
- grp_release_i, in, 1, release from the enabled group (grp_release_o of the pixel_groups level).
- enable_o, out, [GRP_ROWS-1:0][GRP_COLS-1:0], one-hot-or-zero group enable map.
- grp_x_o, out, ADDR_W, column of the granted/reported group.
- grp_y_o, out, ADDR_W, row of the granted/reported group.
- ts_o, out, TS_W, timestamp latched at grant.
- evt_valid_o, out, 1, event valid.
- evt_ready_i, in, 1, downstream ready.
- busy_o, out, 1, high whenever the FSM is not in IDLE.
- timeout_o, out, 1, one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (asynchronous, active when reset_i = 0):
  - state = IDLE; ptr = 0; hold_cnt = 0; ts counter = 0.
  - All outputs are 0: enable_o, grp_x_o, grp_y_o, ts_o, evt_valid_o, busy_o and timeout_o.
  - If reset is asserted mid-grant, enable_o drops immediately and asynchronously. No event and no timeout pulse is produced.
- Flat index: idx = row*GRP_COLS + col, with N = GRP_ROWS*GRP_COLS.
- Timestamp counter: increments every cycle and wraps from 2**TS_W-1 to 0.
- All outputs are registered.
- IDLE:
  - enable_o = 0.
  - If any grp_req_i bit is set, select the first set idx scanning ptr, ptr+1, … N-1, 0, … ptr-1.
  - Next cycle, move to GRANT with the following registered outputs: enable_o one-hot at the selected idx; grp_x_o = col; grp_y_o = row; ts_o = counter value from the selection cycle; hold_cnt = 0.
  - Latency: a request seen in cycle n gives enable_o in cycle n+1.
- GRANT:
  - enable_o is held stable. Dropping grp_req_i for the granted group does not revoke the enable.
  - When grp_release_i = 1: next cycle, enable_o = 0, evt_valid_o = 1, go to REPORT.
  - Otherwise, if hold_cnt == TIMEOUT-1: next cycle, enable_o = 0, timeout_o = 1 for exactly one cycle, ptr = granted idx + 1 (mod N), go to IDLE.
  - Otherwise, hold_cnt increments.
  - Net effect: enable_o is high at most TIMEOUT cycles.
  - If release and timeout occur in the same cycle, release wins and no timeout pulse is produced.
- REPORT:
  - evt_valid_o = 1; grp_x_o, grp_y_o and ts_o are stable while valid is high and ready is low.
  - No new grant is issued. New requests are ignored until the FSM returns to IDLE.
  - When evt_valid_o && evt_ready_i: next cycle, evt_valid_o = 0, ptr = granted idx + 1 (mod N), go to IDLE.
  - Minimum gap between two grants: 1 IDLE cycle.
- ptr wrap-around: granting idx N-1 sets ptr to 0.
- Enable encoding: enable_o is never multi-hot.
- Address outputs: grp_x_o, grp_y_o and ts_o keep their last values in IDLE. They are meaningful only while enable_o ≠ 0 or evt_valid_o = 1.

Test Plan:
1. Reset, then grp_req_i bits at idx 2 and 9 held (4x4 map) -> enable_o idx 2 one cycle later with x=2, y=0. Release, then handshake with ready=1 -> after 1 IDLE cycle, enable idx 9 with x=1, y=2.
2. Wrap: only idx 15 requesting, ptr=0 -> grant 15. After the handshake, idx 0 and 15 requesting -> grant idx 0 next (ptr wrapped to 0).
3. Timeout: grant idx 5 with grp_release_i never asserted, TIMEOUT=15 -> enable_o high exactly 15 cycles, then 0, timeout_o pulses one cycle, evt_valid_o stays 0, next grant starts scanning at idx 6.
4. Backpressure: release with evt_ready_i low for 5 cycles -> evt_valid_o stays 1, x/y/ts unchanged, enable_o = 0 throughout, no new grant. Ready at cycle 6 -> valid drops next cycle.
5. Timestamp: grant issued when counter = 0xFFFF -> ts_o = 0xFFFF. A later grant 3 cycles after that selection -> ts_o = 0x0002 (counter wrapped).
6. Reset mid-GRANT (reset_i low, asynchronous to clk_i) -> enable_o and busy_o drop immediately. After release of reset, ptr = 0 and the first request from idx 0 is granted.
